// File: rtl/ext_arbiter.sv
// Round-robin arbiter sharing one sign/zero-extension datapath between two requesters,
// returning results through a single-entry registered valid/ready output stage.

module sign_extend #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 16
) (
  input  logic [N-1:0] d_i,
  output logic [M-1:0] q_o
);

  assign q_o = {{(M-N){d_i[N-1]}}, d_i};

endmodule

module ext_arbiter #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  input  logic [N-1:0] req_data0,
  input  logic [N-1:0] req_data1,
  input  logic [1:0]   req_signed,
  output logic [1:0]   req_ready,
  output logic         out_valid,
  output logic [M-1:0] out_data,
  output logic         out_id,
  input  logic         out_ready,
  output logic [7:0]   busy_cnt
);

  localparam int unsigned BusyW   = 8;
  localparam logic [BusyW-1:0] BusyMax = 8'hFF;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           state_q;
  logic [M-1:0]     data_q;
  logic             id_q;
  logic             rr_q;
  logic [BusyW-1:0] busy_q;

  logic             can_accept;
  logic [1:0]       grant;
  logic             win_id;
  logic             fire;
  logic [N-1:0]     sel_data;
  logic             sel_signed;
  logic [M-1:0]     sext_data;
  logic [M-1:0]     ext_data;

  assign can_accept = (state_q == ST_EMPTY) | out_ready;

  // Contention resolves toward rr_q; a lone requester always wins.
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
      grant = rr_q ? 2'b10 : 2'b01;
    end
  end

  assign win_id     = grant[1];
  assign fire       = can_accept & (|req_valid);
  assign req_ready  = grant & {2{can_accept & rst_n}};

  assign sel_data   = win_id ? req_data1 : req_data0;
  assign sel_signed = req_signed[win_id];

  sign_extend #(.N(N), .M(M)) u_sext (
    .d_i (sel_data),
    .q_o (sext_data)
  );

  assign ext_data = sel_signed ? sext_data : M'(sel_data);

  // Output stage FSM; in FULL a retiring result and a new capture share one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      id_q    <= 1'b0;
      rr_q    <= 1'b0;
      busy_q  <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (fire) begin
            state_q <= ST_FULL;
            data_q  <= ext_data;
            id_q    <= win_id;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (fire) begin
              data_q <= ext_data;
              id_q   <= win_id;
            end else begin
              state_q <= ST_EMPTY;
            end
          end
        end
      endcase
      if (fire) begin
        rr_q <= ~win_id;
      end
      if ((state_q == ST_FULL) && !out_ready && (busy_q != BusyMax)) begin
        busy_q <= busy_q + BusyW'(1);
      end
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign busy_cnt  = busy_q;

endmodule

// File: tb/tb_ext_arbiter.sv
// Scoreboard bench for ext_arbiter: a negedge monitor predicts grants and results,
// per-feature tasks add directed checks on top.

module tb_ext_arbiter;

  localparam int unsigned N = 8;
  localparam int unsigned M = 16;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [N-1:0] req_data0;
  logic [N-1:0] req_data1;
  logic [1:0]   req_signed;
  logic [1:0]   req_ready;
  logic         out_valid;
  logic [M-1:0] out_data;
  logic         out_id;
  logic         out_ready;
  logic [7:0]   busy_cnt;

  ext_arbiter #(.N(N), .M(M)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .req_signed (req_signed),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .busy_cnt   (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         id;
    logic [M-1:0] data;
  } exp_t;

  exp_t       sb_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic       m_valid;
  logic       m_rr;
  logic [7:0] m_busy;
  logic [1:0] last_acc;

  function automatic logic [M-1:0] ext_model(input logic [N-1:0] d, input logic s);
    if (s) ext_model = {{(M-N){d[N-1]}}, d};
    else   ext_model = {{(M-N){1'b0}}, d};
  endfunction

  // Reference model: expected handshakes, occupancy, stall count and result order.
  always @(negedge clk) begin : monitor
    logic       can;
    logic [1:0] g;
    logic [1:0] exp_rdy;
    exp_t       e;
    exp_t       got;
    if (!rst_n) begin
      sb_q.delete();
      m_valid  = 1'b0;
      m_rr     = 1'b0;
      m_busy   = 8'h00;
      last_acc = 2'b00;
    end else begin
      can = !m_valid || out_ready;
      g = (req_valid == 2'b11) ? (m_rr ? 2'b10 : 2'b01) : req_valid;
      exp_rdy = can ? g : 2'b00;
      n_vec++;
      if (req_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL sb_req_ready t=%0t got=%b exp=%b", $time, req_ready, exp_rdy);
      end
      n_vec++;
      if (out_valid !== m_valid) begin
        n_err++;
        $display("FAIL sb_out_valid t=%0t got=%b exp=%b", $time, out_valid, m_valid);
      end
      n_vec++;
      if (busy_cnt !== m_busy) begin
        n_err++;
        $display("FAIL sb_busy_cnt t=%0t got=%h exp=%h", $time, busy_cnt, m_busy);
      end
      if (m_valid && out_ready) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_underflow t=%0t got=result exp=empty", $time);
        end else begin
          e   = sb_q.pop_front();
          got = {out_id, out_data};
          if (got !== e) begin
            n_err++;
            $display("FAIL sb_result t=%0t got=id%0d/%h exp=id%0d/%h",
                     $time, out_id, out_data, e.id, e.data);
          end
        end
      end
      if (m_valid && !out_ready && m_busy != 8'hFF) m_busy = m_busy + 8'd1;
      last_acc = req_valid & exp_rdy;
      if (|exp_rdy) begin
        e.id   = exp_rdy[1];
        e.data = ext_model(exp_rdy[1] ? req_data1 : req_data0, req_signed[exp_rdy[1]]);
        sb_q.push_back(e);
        m_rr    = ~exp_rdy[1];
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_data0  = 8'h55;
    req_data1  = 8'hAA;
    req_signed = 2'b11;
    out_ready  = 1'b0;
    #3;
    n_vec++;
    if ({out_valid, out_data, out_id, req_ready, busy_cnt} !== 28'h0) begin
      n_err++;
      $display("FAIL reset_init got=v%b d%h id%b rdy%b busy%h exp=all zero",
               out_valid, out_data, out_id, req_ready, busy_cnt);
    end
    req_valid = 2'b01;
    req_data0 = 8'h12;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    req_valid = 2'b00;
    tick();
    #2;
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_data, req_ready} !== 19'h0) begin
      n_err++;
      $display("FAIL reset_midfull got=v%b d%h rdy%b exp=v0 d0000 rdy00",
               out_valid, out_data, req_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL reset_first_grant got=%b exp=01", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || out_id !== 1'b0) begin
      n_err++;
      $display("FAIL reset_first_id got=v%b id%b exp=v1 id0", out_valid, out_id);
    end
    tick();
  endtask

  task automatic test_signed();
    logic [N-1:0] d_tab [3];
    logic         s_tab [3];
    logic [M-1:0] e_tab [3];
    d_tab = '{8'h80, 8'h80, 8'h7F};
    s_tab = '{1'b1, 1'b0, 1'b1};
    e_tab = '{16'hFF80, 16'h0080, 16'h007F};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid  = 2'b01;
      req_data0  = d_tab[i];
      req_signed = {1'b0, s_tab[i]};
      tick();
      req_valid = 2'b00;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== e_tab[i] || out_id !== 1'b0) begin
        n_err++;
        $display("FAIL signed_ext[%0d] got=v%b %h id%b exp=v1 %h id0",
                 i, out_valid, out_data, out_id, e_tab[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_contention();
    logic [1:0] prev_rdy;
    req_valid  = 2'b11;
    req_data0  = 8'hA5;
    req_data1  = 8'h3C;
    req_signed = 2'b01;
    out_ready  = 1'b1;
    prev_rdy   = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_vec++;
        if (req_ready !== {prev_rdy[0], prev_rdy[1]} || out_valid !== 1'b1 ||
            out_id !== prev_rdy[1]) begin
          n_err++;
          $display("FAIL contention[%0d] got=rdy%b id%b exp=rdy%b id%b",
                   i, req_ready, out_id, {prev_rdy[0], prev_rdy[1]}, prev_rdy[1]);
        end
      end
      prev_rdy = req_ready;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back_backpressure();
    logic [M-1:0] hold_data;
    logic         hold_id;
    logic [7:0]   busy0;
    req_valid = 2'b11;
    out_ready = 1'b0;
    @(negedge clk);
    hold_data = out_data;
    hold_id   = out_id;
    busy0     = busy_cnt;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_vec++;
      if (out_data !== hold_data || out_id !== hold_id || req_ready !== 2'b00) begin
        n_err++;
        $display("FAIL stall_hold[%0d] got=%h id%b rdy%b exp=%h id%b rdy00",
                 i, out_data, out_id, req_ready, hold_data, hold_id);
      end
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy_cnt !== 8'(busy0 + 8'd5) || req_ready !== (hold_id ? 2'b01 : 2'b10)) begin
      n_err++;
      $display("FAIL stall_release got=busy%h rdy%b exp=busy%h rdy%b",
               busy_cnt, req_ready, 8'(busy0 + 8'd5), hold_id ? 2'b01 : 2'b10);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || out_id !== ~hold_id) begin
      n_err++;
      $display("FAIL stall_reload got=v%b id%b exp=v1 id%b", out_valid, out_id, ~hold_id);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    req_valid = 2'b11;
    out_ready = 1'b0;
    repeat (300) tick();
    @(negedge clk);
    n_vec++;
    if (busy_cnt !== 8'hFF) begin
      n_err++;
      $display("FAIL busy_sat got=%h exp=ff", busy_cnt);
    end
    repeat (5) tick();
    @(negedge clk);
    n_vec++;
    if (busy_cnt !== 8'hFF) begin
      n_err++;
      $display("FAIL busy_sticky got=%h exp=ff", busy_cnt);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!(req_valid[r] && !last_acc[r])) begin
          req_valid[r]  = ($urandom_range(0, 99) < 60);
          req_signed[r] = 1'($urandom_range(0, 1));
          if (r == 0) req_data0 = 8'($urandom);
          else        req_data1 = 8'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    req_valid = 2'b00;
    out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL random_drain got=pending%0d v%b exp=pending0 v0", sb_q.size(), out_valid);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_signed();
    test_contention();
    test_back_to_back_backpressure();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
